// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_control_unit
// Purpose  : Pipeline hazard and stall controller that sits upstream of the
//            forwarding logic. It detects the hazards that forwarding cannot
//            cover and drives the pipeline-register control signals.
//              - Load-use hazard: a load in EX feeds the instruction in ID.
//              - Branch hazard: the ID branch compare needs a result that is
//                not yet available (ALU result in EX, or load data in MEM).
//              - Freeze: the whole pipeline holds while data memory is busy.
//              - Flush: IF/ID is cleared on a taken ID-stage branch.
//            A watchdog on memory wait enters a sticky FAULT state, and two
//            saturating performance counters track stalls and flushes.
// Ports    : clk, rst                   clock, synchronous active-high reset
//            if_id_* / id_ex_* / ex_mem_*  pipeline register fields
//            branch_taken               ID branch resolved taken
//            dmem_req, dmem_ready       data-memory handshake
//            pc_we, *_we                register write enables
//            if_id_flush, id_ex_flush   NOP insertion into IF/ID and ID/EX
//            mem_fault                  sticky memory-timeout flag
//            stall_cycles, flush_count  saturating performance counters
// Revision : 1.0 - initial release
// ============================================================================
module hazard_control_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_use_rs1,
    input  logic             if_id_use_rs2,
    input  logic             if_id_is_branch,
    input  logic             branch_taken,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_reg_write,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       ex_mem_rd,
    input  logic             ex_mem_mem_read,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] c_TIMEOUT = WCW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WCW-1:0]   r_wait_cnt;
    logic [WCW-1:0]   w_wait_cnt_next;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    logic w_match_ex;
    logic w_match_mem;
    logic w_load_use;
    logic w_br_haz;
    logic w_stall;
    logic w_freeze;

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] r,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2,
                                       input logic       use1,
                                       input logic       use2);
        return (r != 5'd0) && (((r == rs1) && use1) || ((r == rs2) && use2));
    endfunction

    always_comb begin
        w_match_ex  = reg_match(id_ex_rd,  if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2);
        w_match_mem = reg_match(ex_mem_rd, if_id_rs1, if_id_rs2, if_id_use_rs1, if_id_use_rs2);
        w_load_use  = id_ex_mem_read && w_match_ex;
        // The branch compares in ID, so it must wait for any EX result and
        // for load data still in MEM; a load therefore costs two stalls.
        w_br_haz    = if_id_is_branch &&
                      ((id_ex_reg_write && w_match_ex) || (ex_mem_mem_read && w_match_mem));
        w_stall     = w_load_use || w_br_haz;
        w_freeze    = (dmem_req && !dmem_ready) || (r_state == FAULT);
    end

    // Control outputs, priority rst > freeze > stall > taken branch.
    always_comb begin
        pc_we       = 1'b1;
        if_id_we    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_we    = 1'b1;
        id_ex_flush = 1'b0;
        ex_mem_we   = 1'b1;
        mem_wb_we   = 1'b1;
        if (rst) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_we    = 1'b0;
            ex_mem_we   = 1'b0;
            mem_wb_we   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_freeze) begin
            pc_we     = 1'b0;
            if_id_we  = 1'b0;
            id_ex_we  = 1'b0;
            ex_mem_we = 1'b0;
            mem_wb_we = 1'b0;
        end else if (w_stall) begin
            // Hold PC and IF/ID, push a bubble into EX; branch_taken is
            // ignored because the compare operands are not valid yet.
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
        end else if (branch_taken) begin
            if_id_flush = 1'b1;
        end
    end

    // Memory-wait watchdog.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    w_state_next    = MEM_WAIT;
                    w_wait_cnt_next = WCW'(1);
                end else begin
                    w_wait_cnt_next = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready || !dmem_req) begin
                    w_state_next    = RUN;
                    w_wait_cnt_next = '0;
                end else if (r_wait_cnt == c_TIMEOUT) begin
                    w_state_next = FAULT;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 1'b1;
                end
            end
            FAULT: begin
                w_state_next = FAULT;
            end
            default: begin
                w_state_next    = RUN;
                w_wait_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= RUN;
            r_wait_cnt     <= '0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if ((w_stall || w_freeze) && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
            if (if_id_flush && (r_flush_count != '1)) begin
                r_flush_count <= r_flush_count + 1'b1;
            end
        end
    end

    assign mem_fault    = (r_state == FAULT);
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule
`default_nettype wire
